tessent_data_mux_sync: RTL
==========================

TESSENT_DATA_MUX_SYNC -- requirements
Module: tessent_data_mux_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 19: data path width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter NUM_SRC, default 4: number of IJTAG data sources, legal range 1..16; SRC_W = max(1, clog2(NUM_SRC)).
REQ-003 The block SHALL have parameter SETTLE, default 2: number of safe-value cycles per path switch, legal range 1..15.
REQ-004 The block SHALL have parameter SAFE_VALUE, default all-zero, WIDTH bits: value driven during a switch.
REQ-005 Port ijtag_tck, input, 1 bit: sole clock; all state updates occur on its rising edge.
REQ-006 Port ijtag_reset, input, 1 bit: reset, synchronous, active-low.
REQ-007 Port ijtag_select, input, 1 bit: 1 requests an IJTAG path; 0 requests the functional path.
REQ-008 Port ijtag_src_sel, input, SRC_W bits: requested IJTAG source index; meaningful only when ijtag_select=1.
REQ-009 Port functional_data_in, input, WIDTH bits: functional data.
REQ-010 Port ijtag_data_in, input, NUM_SRC*WIDTH bits: source k occupies bits [k*WIDTH +: WIDTH].
REQ-011 Port data_out, output, WIDTH bits: registered selected data.
REQ-012 Port switch_busy, output, 1 bit: high during every settle cycle.
REQ-013 Port active_ijtag, output, 1 bit: currently committed path is IJTAG.
REQ-014 Port active_src, output, SRC_W bits: currently committed source index; 0 when active_ijtag=0.

Function
REQ-015 The request SHALL be the pair {ijtag_select, ijtag_src_sel}, with src forced to 0 when ijtag_select=0; an out-of-range src (>= NUM_SRC) SHALL be treated as NUM_SRC-1.
REQ-016 The FSM SHALL have exactly two states: STABLE and SETTLE.
REQ-017 In STABLE with request equal to committed path, data_out SHALL load the committed path's input each cycle (latency 1 cycle); switch_busy SHALL be 0.
REQ-018 In STABLE with request differing from committed path, the block SHALL latch the request as target, load the counter with SETTLE-1, enter SETTLE, and load data_out with SAFE_VALUE on the same edge.
REQ-019 In SETTLE, data_out SHALL load SAFE_VALUE, switch_busy SHALL be 1, and the counter SHALL decrement each cycle.
REQ-020 In SETTLE with counter = 0, the block SHALL commit the target (update active_ijtag/active_src), return to STABLE, and load data_out from the new path on that same edge.
REQ-021 Request changes during SETTLE SHALL be ignored; after return to STABLE, a request differing from the committed path SHALL start a new settle on the next edge.
REQ-022 A switch SHALL produce exactly SETTLE consecutive cycles of SAFE_VALUE on data_out and SETTLE cycles of switch_busy=1.
REQ-023 A change of ijtag_src_sel while ijtag_select=0 SHALL NOT cause a switch.
REQ-024 With NUM_SRC=1, only ijtag_select toggles SHALL cause switches.

Reset
REQ-025 While ijtag_reset=0 at a rising edge: state=STABLE, committed path=functional, active_ijtag=0, active_src=0, switch_busy=0, data_out=SAFE_VALUE, counter=0.
REQ-026 Reset asserted mid-SETTLE SHALL abandon the target; after release, the first edge SHALL load data_out from functional_data_in, or start a settle if an IJTAG path is requested.

Structure
REQ-027 A shared package tessent_data_mux_sync_pkg SHALL hold the state enum (STABLE, SETTLE) and the counter width constant (4 bits).
REQ-028 The NUM_SRC:1 combinational source selector SHALL be a sub-module named tessent_data_mux_sync_sel; the FSM, counter, and output registers SHALL reside in the top module.

Verification (WIDTH=19, NUM_SRC=4, SETTLE=2, SAFE_VALUE=0)
REQ-029 Reset, functional_data_in=19'h1234 -> data_out=0 during reset, 19'h1234 one cycle after release, busy=0.
REQ-030 Source 2 = 19'h7ABCD; raise ijtag_select with src_sel=2 -> data_out 0 for 2 cycles with busy=1, then 19'h7ABCD, active_ijtag=1, active_src=2.
REQ-031 In source 2, switch src_sel to 3 during cycle 1 of a settle, then switch back to 2 -> first settle completes to the latched target; a second settle follows if the request differs; data_out is never a non-zero value from an uncommitted path.
REQ-032 ijtag_select=0 while src_sel toggles 0..3 -> no busy pulse; data_out tracks functional_data_in with 1-cycle latency.
REQ-033 Assert reset on settle cycle 1 of a switch to source 1 -> active_ijtag=0, data_out=0; after release, with request held, a full 2-cycle settle runs to source 1.
REQ-034 src_sel=3'b? out-of-range case using NUM_SRC=3, src_sel=3 -> commits active_src=2 and data_out equals source 2.

Source files
------------

// File: rtl/tessent_data_mux_sync_pkg.sv
// Shared types and constants for the IJTAG/functional data mux with safe-value switching.
package tessent_data_mux_sync_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_t;

endpackage

// File: rtl/tessent_data_mux_sync_sel.sv
// NUM_SRC:1 combinational selector over the packed IJTAG source bus (AND-OR structure).
module tessent_data_mux_sync_sel #(
  parameter int WIDTH   = 19,
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC*WIDTH-1:0] data_in,
  input  logic [SRC_W-1:0]         sel,
  output logic [WIDTH-1:0]         data_sel
);

  logic [WIDTH-1:0] masked [NUM_SRC];

  // Each source is gated by its own index match, so no index ever falls outside the bus.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign masked[gi] = (sel == SRC_W'(gi)) ? data_in[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      data_sel = data_sel | masked[i];
    end
  end

endmodule

// File: rtl/tessent_data_mux_sync.sv
// Registered functional/IJTAG data mux; every path change inserts SETTLE cycles of SAFE_VALUE.
module tessent_data_mux_sync
  import tessent_data_mux_sync_pkg::*;
#(
  parameter int              WIDTH      = 19,
  parameter int              NUM_SRC    = 4,
  parameter int              SETTLE     = 2,
  parameter logic [WIDTH-1:0] SAFE_VALUE = '0,
  localparam int             SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     ijtag_tck,
  input  logic                     ijtag_reset,
  input  logic                     ijtag_select,
  input  logic [SRC_W-1:0]         ijtag_src_sel,
  input  logic [WIDTH-1:0]         functional_data_in,
  input  logic [NUM_SRC*WIDTH-1:0] ijtag_data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     switch_busy,
  output logic                     active_ijtag,
  output logic [SRC_W-1:0]         active_src
);

  // The SETTLE parameter shadows the enum literal, so the state is named through the package.
  localparam state_t ST_SETTLE = tessent_data_mux_sync_pkg::SETTLE;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             active_ijtag_reg, active_ijtag_next;
  logic [SRC_W-1:0] active_src_reg, active_src_next;
  logic             tgt_ijtag_reg, tgt_ijtag_next;
  logic [SRC_W-1:0] tgt_src_reg, tgt_src_next;
  logic [WIDTH-1:0] data_reg, data_next;

  logic             req_ijtag;
  logic [SRC_W-1:0] req_src;
  logic             req_differs;
  logic             path_ijtag;
  logic [SRC_W-1:0] path_src;
  logic [WIDTH-1:0] ijtag_sel_data;
  logic [WIDTH-1:0] path_data;

  // Out-of-range source indices saturate to the last source.
  always_comb begin
    req_ijtag = ijtag_select;
    req_src   = '0;
    if (ijtag_select) begin
      if ({1'b0, ijtag_src_sel} >= (SRC_W+1)'(NUM_SRC)) begin
        req_src = SRC_W'(NUM_SRC - 1);
      end else begin
        req_src = ijtag_src_sel;
      end
    end
  end

  assign req_differs = ({req_ijtag, req_src} != {active_ijtag_reg, active_src_reg});

  // While settling, the path being fed is the target, so the commit edge loads new data.
  assign path_ijtag = (state_reg == ST_SETTLE) ? tgt_ijtag_reg : active_ijtag_reg;
  assign path_src   = (state_reg == ST_SETTLE) ? tgt_src_reg   : active_src_reg;

  tessent_data_mux_sync_sel #(
    .WIDTH   (WIDTH),
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_sel (
    .data_in  (ijtag_data_in),
    .sel      (path_src),
    .data_sel (ijtag_sel_data)
  );

  assign path_data = path_ijtag ? ijtag_sel_data : functional_data_in;

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    active_ijtag_next = active_ijtag_reg;
    active_src_next   = active_src_reg;
    tgt_ijtag_next    = tgt_ijtag_reg;
    tgt_src_next      = tgt_src_reg;
    data_next         = data_reg;
    case (state_reg)
      STABLE: begin
        if (req_differs) begin
          tgt_ijtag_next = req_ijtag;
          tgt_src_next   = req_src;
          cnt_next       = CNT_W'(SETTLE - 1);
          state_next     = ST_SETTLE;
          data_next      = SAFE_VALUE;
        end else begin
          data_next = path_data;
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == '0) begin
          active_ijtag_next = tgt_ijtag_reg;
          active_src_next   = tgt_src_reg;
          state_next        = STABLE;
          data_next         = path_data;
        end else begin
          cnt_next  = cnt_reg - CNT_W'(1);
          data_next = SAFE_VALUE;
        end
      end
      default: begin
        state_next = STABLE;
        data_next  = SAFE_VALUE;
      end
    endcase
  end

  always_ff @(posedge ijtag_tck) begin
    if (!ijtag_reset) begin
      state_reg        <= STABLE;
      cnt_reg          <= '0;
      active_ijtag_reg <= 1'b0;
      active_src_reg   <= '0;
      tgt_ijtag_reg    <= 1'b0;
      tgt_src_reg      <= '0;
      data_reg         <= SAFE_VALUE;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      active_ijtag_reg <= active_ijtag_next;
      active_src_reg   <= active_src_next;
      tgt_ijtag_reg    <= tgt_ijtag_next;
      tgt_src_reg      <= tgt_src_next;
      data_reg         <= data_next;
    end
  end

  assign data_out     = data_reg;
  assign switch_busy  = (state_reg == ST_SETTLE);
  assign active_ijtag = active_ijtag_reg;
  assign active_src   = active_src_reg;

endmodule
